lfsr_seq_ctrl: RTL and testbench

Burst sequencer for the 32-bit LFSR application unit inside the CCI-P AFU. Software writes a step count and a START command over MMIO. The block then asserts the LFSR step enable for exactly that many clock cycles, captures the final LFSR value and reports completion. It sits between the AFU MMIO write decode and the LFSR datapath. It exposes status and snapshot values to the AFU MMIO read mux.

---
 rtl/lfsr_seq_ctrl_if.sv | 9 +
 rtl/lfsr_seq_ctrl.sv | 137 +++++++++++++
 tb/tb_lfsr_seq_ctrl.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/lfsr_seq_ctrl_if.sv
// rtl/lfsr_seq_ctrl_if.sv - MMIO write bus into the LFSR burst sequencer
interface lfsr_seq_ctrl_if;
    logic        W;
    logic [15:0] A;
    logic [63:0] D;

    modport master (output W, output A, output D);
    modport slave  (input W, input A, input D);
endinterface

// File: rtl/lfsr_seq_ctrl.sv
// rtl/lfsr_seq_ctrl.sv - issues a counted burst of LFSR steps and snapshots the result
module lfsr_seq_ctrl #(
    parameter int n     = 32,
    parameter int CNT_W = 32
) (
    input  logic             clock,
    input  logic             reset,
    lfsr_seq_ctrl_if.slave   mmio,
    input  logic [n-1:0]     Q,
    output logic             step_en,
    output logic             busy,
    output logic             done,
    output logic             done_pulse,
    output logic             aborted,
    output logic             err,
    output logic [CNT_W-1:0] remaining,
    output logic [CNT_W-1:0] steps_done,
    output logic [n-1:0]     snapshot
);
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_RUN     = 2'd1;
    localparam logic [1:0] ST_CAPTURE = 2'd2;
    localparam logic [1:0] ST_DONE    = 2'd3;

    localparam logic [15:0]      ADDR_COUNT = 16'h0016;
    localparam logic [15:0]      ADDR_CMD   = 16'h0018;
    localparam logic [CNT_W-1:0] CNT_MAX    = '1;

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] remaining_q, remaining_d;
    logic [CNT_W-1:0] steps_done_q, steps_done_d;
    logic [n-1:0]     snapshot_q, snapshot_d;
    logic             aborted_q, aborted_d;
    logic             err_q, err_d;
    logic             done_pulse_q, done_pulse_d;
    logic             step_en_q, busy_q, done_q;

    logic wr_count, wr_cmd, cmd_start, cmd_abort, cmd_clear;

    always_comb begin
        wr_count  = mmio.W && (mmio.A == ADDR_COUNT);
        wr_cmd    = mmio.W && (mmio.A == ADDR_CMD);
        cmd_start = wr_cmd && mmio.D[0];
        cmd_abort = wr_cmd && mmio.D[1];
        cmd_clear = wr_cmd && mmio.D[2];
    end

    always_comb begin
        state_d      = state_q;
        count_d      = wr_count ? mmio.D[CNT_W-1:0] : count_q;
        remaining_d  = remaining_q;
        steps_done_d = steps_done_q;
        snapshot_d   = snapshot_q;
        aborted_d    = aborted_q;
        err_d        = err_q;
        done_pulse_d = 1'b0;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                // ABORT outranks the others but has nothing to stop here
                if (cmd_abort) begin
                    state_d = state_q;
                end else if (cmd_clear) begin
                    state_d   = ST_IDLE;
                    aborted_d = 1'b0;
                    err_d     = 1'b0;
                end else if (cmd_start) begin
                    remaining_d  = count_q;
                    steps_done_d = '0;
                    aborted_d    = 1'b0;
                    state_d      = (count_q != '0) ? ST_RUN : ST_CAPTURE;
                end
            end
            ST_RUN: begin
                // The step in this cycle counts even when ABORT arrives with it
                if (remaining_q != '0)
                    remaining_d = remaining_q - 1'b1;
                if (steps_done_q != CNT_MAX)
                    steps_done_d = steps_done_q + 1'b1;
                if (cmd_abort) begin
                    state_d   = ST_CAPTURE;
                    aborted_d = 1'b1;
                end else if (remaining_q <= 1) begin
                    state_d = ST_CAPTURE;
                end
                if (cmd_start && !cmd_abort && !cmd_clear)
                    err_d = 1'b1;
            end
            default: begin
                snapshot_d   = Q;
                state_d      = ST_DONE;
                done_pulse_d = 1'b1;
                if (cmd_start && !cmd_abort && !cmd_clear)
                    err_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            count_q      <= '0;
            remaining_q  <= '0;
            steps_done_q <= '0;
            snapshot_q   <= '0;
            aborted_q    <= 1'b0;
            err_q        <= 1'b0;
            done_pulse_q <= 1'b0;
            step_en_q    <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            remaining_q  <= remaining_d;
            steps_done_q <= steps_done_d;
            snapshot_q   <= snapshot_d;
            aborted_q    <= aborted_d;
            err_q        <= err_d;
            done_pulse_q <= done_pulse_d;
            step_en_q    <= (state_d == ST_RUN);
            busy_q       <= (state_d == ST_RUN) || (state_d == ST_CAPTURE);
            done_q       <= (state_d == ST_DONE);
        end
    end

    assign step_en    = step_en_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign done_pulse = done_pulse_q;
    assign aborted    = aborted_q;
    assign err        = err_q;
    assign remaining  = remaining_q;
    assign steps_done = steps_done_q;
    assign snapshot   = snapshot_q;
endmodule

// File: tb/tb_lfsr_seq_ctrl.sv
// tb/tb_lfsr_seq_ctrl.sv - directed checks of the LFSR burst sequencer
module tb_lfsr_seq_ctrl;
    localparam logic [31:0] POLY = 32'h80200003;
    localparam int          LIM  = 300;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] Q;
    logic        q_load;
    logic [31:0] q_seed;
    logic        step_en, busy, done, done_pulse, aborted, err;
    logic [31:0] remaining, steps_done, snapshot;

    int checks = 0;
    int errors = 0;

    lfsr_seq_ctrl_if mmio ();

    lfsr_seq_ctrl #(.n(32), .CNT_W(32)) dut (
        .clock      (clock),
        .reset      (reset),
        .mmio       (mmio),
        .Q          (Q),
        .step_en    (step_en),
        .busy       (busy),
        .done       (done),
        .done_pulse (done_pulse),
        .aborted    (aborted),
        .err        (err),
        .remaining  (remaining),
        .steps_done (steps_done),
        .snapshot   (snapshot)
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] lfsr_next(input logic [31:0] s);
        return s[0] ? ((s >> 1) ^ POLY) : (s >> 1);
    endfunction

    // Stand-in LFSR datapath
    always @(posedge clock) begin
        if (q_load)       Q <= q_seed;
        else if (step_en) Q <= lfsr_next(Q);
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic mmio_wr(input logic [15:0] addr, input logic [63:0] data);
        @(negedge clock);
        mmio.W = 1'b1; mmio.A = addr; mmio.D = data;
        @(negedge clock);
        mmio.W = 1'b0; mmio.A = '0; mmio.D = '0;
    endtask

    task automatic seed(input logic [31:0] v);
        @(negedge clock);
        q_load = 1'b1; q_seed = v;
        @(negedge clock);
        q_load = 1'b0;
    endtask

    // Called right after the START write returns: counts step_en cycles and done latency
    task automatic run_to_done(output int en_cnt, output int lat);
        int k;
        k = 1;
        en_cnt = 0;
        while (k <= LIM) begin
            if (step_en) en_cnt++;
            if (done) break;
            @(negedge clock);
            k++;
        end
        lat = k;
    endtask

    logic [31:0] exp_q;
    int          en_cnt, lat;

    initial begin
        reset = 1'b1; q_load = 1'b0; q_seed = '0;
        mmio.W = 1'b0; mmio.A = '0; mmio.D = '0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        check("reset_flags", {step_en, busy, done, done_pulse, aborted, err}, 6'b0);
        check("reset_cnts", {remaining, steps_done, snapshot}, 96'b0);

        // COUNT=5 burst from seed 1
        seed(32'h1);
        exp_q = 32'h1;
        for (int i = 0; i < 5; i++) exp_q = lfsr_next(exp_q);
        mmio_wr(16'h0016, 64'd5);
        mmio_wr(16'h0018, 64'h1);
        check("b5_busy_first", {step_en, busy}, 2'b11);
        run_to_done(en_cnt, lat);
        check("b5_step_cycles", en_cnt, 5);
        check("b5_done_lat", lat, 7);
        check("b5_pulse", done_pulse, 1'b1);
        check("b5_snapshot", snapshot, exp_q);
        check("b5_counts", {steps_done, remaining, aborted, err}, {32'd5, 32'd0, 2'b00});
        @(negedge clock);
        check("b5_pulse_single", {done_pulse, done, busy}, 3'b010);

        // COUNT=0: capture only
        seed(32'hDEADBEEF);
        mmio_wr(16'h0016, 64'd0);
        mmio_wr(16'h0018, 64'h1);
        run_to_done(en_cnt, lat);
        check("z_step_cycles", en_cnt, 0);
        check("z_done_lat", lat, 2);
        check("z_snapshot", snapshot, 32'hDEADBEEF);
        check("z_steps_done", steps_done, 32'd0);

        // COUNT=100, ABORT written in cycle t+10
        mmio_wr(16'h0016, 64'd100);
        mmio_wr(16'h0018, 64'h1);
        repeat (8) @(negedge clock);
        mmio_wr(16'h0018, 64'h2);
        check("ab_step_low", {step_en, busy, done}, 3'b010);
        @(negedge clock);
        check("ab_done", {done, done_pulse, aborted}, 3'b111);
        check("ab_counts", {steps_done, remaining}, {32'd10, 32'd90});

        // COUNT=20 with a stray START and COUNT write during RUN
        seed(32'h12345678);
        exp_q = 32'h12345678;
        for (int i = 0; i < 20; i++) exp_q = lfsr_next(exp_q);
        mmio_wr(16'h0016, 64'd20);
        mmio_wr(16'h0018, 64'h1);
        check("rs_aborted_cleared", aborted, 1'b0);
        mmio_wr(16'h0018, 64'h1);
        mmio_wr(16'h0016, 64'd7);
        check("rs_err", err, 1'b1);
        run_to_done(en_cnt, lat);
        check("rs_done_lat", lat, 18);
        check("rs_step_cycles", en_cnt, 16);
        check("rs_steps_done", steps_done, 32'd20);
        check("rs_snapshot", snapshot, exp_q);
        mmio_wr(16'h0018, 64'h4);
        check("clr_state", {done, busy, err, aborted}, 4'b0000);
        check("clr_retained", {steps_done, snapshot}, {32'd20, exp_q});

        // ABORT and START in one write during RUN
        mmio_wr(16'h0016, 64'd30);
        mmio_wr(16'h0018, 64'h1);
        mmio_wr(16'h0018, 64'h3);
        check("as_step_low", {step_en, busy}, 2'b01);
        @(negedge clock);
        check("as_done", {done, aborted, err}, 3'b110);
        check("as_counts", {steps_done, remaining}, {32'd2, 32'd28});
        @(negedge clock);
        check("as_no_restart", {done, step_en, busy}, 3'b100);

        // Reset after 7 steps of a COUNT=50 burst
        mmio_wr(16'h0016, 64'd50);
        mmio_wr(16'h0018, 64'h1);
        repeat (6) @(negedge clock);
        check("rst_pre", {step_en, steps_done}, {1'b1, 32'd6});
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        check("rst_flags", {step_en, busy, done, done_pulse, aborted, err}, 6'b0);
        check("rst_cnts", {remaining, steps_done, snapshot}, 96'b0);
        mmio_wr(16'h0016, 64'd3);
        mmio_wr(16'h0018, 64'h1);
        run_to_done(en_cnt, lat);
        check("post_step_cycles", en_cnt, 3);
        check("post_done_lat", lat, 5);
        check("post_steps_done", steps_done, 32'd3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
